fft_sdf_ctrl: RTL
=================

# fft_sdf_ctrl

Sequencer for the radix-2 single-path delay-feedback (SDF) FFT pipeline built from `bfi` butterfly stages. It accepts a streamed sample sequence through a valid/ready handshake and drives the shared stage enable and the per-stage `control_bit` vector. It flushes the final frame with zero samples and tags pipeline outputs with valid/start/end-of-frame markers. It sits between the sample source and the butterfly chain. The datapath zero-selects its input while `zero_in` is high.

## Interface

Parameters:

- `N_POINTS`, 16: FFT length; must be a power of 2, at least 4.
- `PIPE_LAT`, 15: number of enabled cycles from a sample entering stage 0 to its result leaving the last stage.
- `LOG2N`: localparam, `$clog2(N_POINTS)`.

Ports:

- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `in_valid`, in, 1: upstream sample present.
- `in_sof`, in, 1: the current sample is index 0 of a frame.
- `in_ready`, out, 1: the controller accepts a sample this cycle.
- `flush`, in, 1: pulse requesting a drain after the current frame.
- `bf_en`, out, 1: enable to every butterfly stage.
- `bf_ctrl`, out, LOG2N: `control_bit` for stage s is `bf_ctrl[s]`.
- `samp_idx`, out, LOG2N: index of the sample entering stage 0 (twiddle ROM address base).
- `zero_in`, out, 1: the datapath drives zero into stage 0.
- `out_valid`, out, 1: the last stage output is a real result.
- `out_sof`, out, 1: the output is bin 0 of a frame.
- `out_eof`, out, 1: the output is bin N-1 of a frame.
- `frame_cnt`, out, 16: number of completed output frames; wraps.
- `err_sof`, out, 1: sticky flag for a misaligned `in_sof`.
- `busy`, out, 1: the state is not IDLE.

## Operation

- States are IDLE, RUN and FLUSH. Reset enters IDLE.
- IDLE:
  - `in_ready`=1.
  - A sample with `in_valid` and `in_sof` is accepted as index 0, with `bf_en`=1. The state moves to RUN.
  - A sample with `in_valid` and no `in_sof` is accepted and discarded, with `bf_en`=0.
  - `flush` is ignored.
- RUN:
  - `in_ready`=1 and `bf_en` = `in_valid`.
  - Each accepted sample increments `cnt` (LOG2N bits) modulo N_POINTS.
  - With `in_valid`=0 everything holds; the pipeline stalls.
- Misaligned `in_sof`: if `in_sof` arrives with `cnt`≠0, set `err_sof`. That sample is treated as index 0 and `cnt` is resynchronised. `err_sof` clears only on reset.
- Flush:
  - `flush` in RUN sets `flush_pend`.
  - FLUSH is entered after the sample with `cnt`=N-1 is accepted while `flush_pend` is set, or immediately when `cnt`=0 and `flush_pend` is set.
  - `flush` together with that last sample counts as pending.
  - On entry, `flush_pend` clears.
- FLUSH:
  - `in_ready`=0, `zero_in`=1, and `bf_en`=1 every cycle for exactly PIPE_LAT cycles.
  - `cnt` keeps advancing.
  - The state then returns to IDLE, with `cnt` reset to 0.
- Stage control is `bf_ctrl[s] = cnt[LOG2N-1-s]`, and `samp_idx = cnt`. Both use the registered `cnt` value for the current cycle.
- Output tagging:
  - A PIPE_LAT-bit shift register `tag` shifts on `bf_en`.
  - The bit shifted in is 1 for an accepted real sample and 0 for a flush sample.
  - `out_valid` is registered: `out_valid <= bf_en & tag[PIPE_LAT-1]`.
- Output framing:
  - An LOG2N-bit `out_idx` increments on each `out_valid`.
  - `out_sof` = `out_valid` & (`out_idx`==0).
  - `out_eof` = `out_valid` & (`out_idx`==N-1).
  - `frame_cnt` increments on `out_eof`.
  - `out_idx` resyncs to 0 when a sample tagged as a misaligned sof emerges. A parallel sof-tag shift register carries that marker.
- `busy`=1 in RUN and FLUSH.

## Timing

- Reset values, applied asynchronously:
  - State IDLE; `cnt`, `out_idx` and `tag` are 0.
  - `out_valid`, `out_sof`, `out_eof`, `err_sof` and `busy` are 0; `frame_cnt` is 0.
  - While `rst`=1: `in_ready`=0, `bf_en`=0 and `zero_in`=0, all forced combinationally.
- `in_ready`, `bf_en` and `zero_in` are combinational from state and inputs, in the same cycle as acceptance.
- `bf_ctrl`, `samp_idx` and all `out_*` signals are registered.
- Latency: the sample accepted at enable k produces `out_valid` in the cycle after enable k+PIPE_LAT.
  - With uninterrupted input, this is PIPE_LAT+1 cycles after acceptance.
  - Input stalls extend it one-for-one.
- `rst` asserted mid-frame aborts immediately. All tags are lost and no partial frame is reported.
- Simultaneous `in_sof` with `cnt`=0 in RUN is normal and does not set `err_sof`.

## Test plan

All tests use N_POINTS=16 and PIPE_LAT=15.

1. **Reset.** Hold `rst`=1 with `in_valid`=1 → `in_ready`=0, `bf_en`=0 and all outputs 0. Release `rst` → `in_ready`=1 in IDLE.
2. **Single frame with flush.** Send 16 continuous samples (first with sof), pulse `flush` at sample 10 → first `out_valid`/`out_sof` 16 cycles after sample 0. Also check:
   - Exactly 16 valids, with `out_eof` on the 16th.
   - `bf_ctrl[0]` toggles every 8 samples and `bf_ctrl[3]` every sample.
   - FLUSH lasts 15 cycles with `zero_in`=1.
   - `frame_cnt`=1, and the state is IDLE afterwards.
3. **Stalls.** Same as test 2 with `in_valid` low every other cycle → identical output sequence. `bf_en` follows `in_valid`, and `bf_ctrl` holds during stalls.
4. **Misaligned sof.** Assert `in_sof` at `cnt`=5 → `err_sof`=1 and `samp_idx`=1 on the next accepted sample. The corresponding output carries `out_sof`.
5. **Back-to-back frames.** Send 3 back-to-back frames, then flush → 48 contiguous `out_valid` cycles, 3 sof/eof pairs, and `frame_cnt`=3.
6. **Pre-sof samples.** Send 4 samples without sof in IDLE → they are accepted, `bf_en`=0, `busy`=0, and no output ever appears.

Source files
------------

// File: rtl/fft_sdf_ctrl.sv
// fft_sdf_ctrl: sequencer for a radix-2 SDF FFT chain, covering input handshake, stage control, flush and output framing.
module fft_sdf_ctrl #(
  parameter int N_POINTS = 16,
  parameter int PIPE_LAT = 15,
  localparam int LOG2N = $clog2(N_POINTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  input  logic             flush,
  output logic             bf_en,
  output logic [LOG2N-1:0] bf_ctrl,
  output logic [LOG2N-1:0] samp_idx,
  output logic             zero_in,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic [15:0]      frame_cnt,
  output logic             err_sof,
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2;
  localparam int FW = $clog2(PIPE_LAT + 1);
  localparam logic [LOG2N-1:0] ONE = 1;
  logic [1:0] state;
  logic [LOG2N-1:0] cnt, out_idx;
  logic [FW-1:0] fcnt;
  logic [PIPE_LAT-1:0] tag, stag;
  logic flush_pend, wrap_flush, acc, mis, go, emit;
  // a pending flush at a frame boundary must not swallow a sample it would then abandon
  always_comb begin
    wrap_flush = state == RUN && flush_pend && cnt == '0;
    in_ready = !rst && state != FLUSH && !wrap_flush;
    zero_in = !rst && state == FLUSH;
    bf_en = !rst && (state == FLUSH || (in_valid && !wrap_flush && (state == RUN || in_sof)));
    acc = bf_en && state != FLUSH;
    mis = acc && state == RUN && in_sof && cnt != '0;
    go = state == RUN && (wrap_flush || (acc && (flush_pend || flush) && !in_sof && cnt == '1));
    emit = bf_en && tag[PIPE_LAT-1];
    busy = state != IDLE;
    samp_idx = cnt;
  end
  for (genvar i = 0; i < LOG2N; i++) begin : g_ctrl
    assign bf_ctrl[i] = cnt[LOG2N-1-i];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      fcnt <= '0;
      flush_pend <= 1'b0;
      tag <= '0;
      stag <= '0;
      out_idx <= '0;
      out_valid <= 1'b0;
      out_sof <= 1'b0;
      out_eof <= 1'b0;
      frame_cnt <= '0;
      err_sof <= 1'b0;
    end else begin
      if (state == IDLE && acc) state <= RUN;
      if (acc) cnt <= in_sof ? ONE : cnt + ONE;
      if (go) begin
        state <= FLUSH;
        flush_pend <= 1'b0;
        fcnt <= '0;
      end else if (state == RUN && flush) flush_pend <= 1'b1;
      if (state == FLUSH) begin
        fcnt <= fcnt + FW'(1);
        cnt <= fcnt == FW'(PIPE_LAT - 1) ? '0 : cnt + ONE;
        if (fcnt == FW'(PIPE_LAT - 1)) state <= IDLE;
      end
      err_sof <= err_sof | mis;
      if (bf_en) begin
        tag <= {tag[PIPE_LAT-2:0], acc};
        stag <= {stag[PIPE_LAT-2:0], mis};
      end
      out_valid <= emit;
      out_sof <= emit && (stag[PIPE_LAT-1] || out_idx == '0);
      out_eof <= emit && !stag[PIPE_LAT-1] && out_idx == '1;
      if (emit) out_idx <= stag[PIPE_LAT-1] ? ONE : out_idx + ONE;
      frame_cnt <= frame_cnt + 16'(emit && !stag[PIPE_LAT-1] && out_idx == '1);
    end
  end
endmodule
